// File: rtl/bijiaoqi_pkg.sv
// Shared state codes, result encoding and width helper for the serial
// magnitude comparator (bijiaoqi_serial / bijiaoqi_digit).
package bijiaoqi_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Result vector packed as {gt, lt, eq}; exactly one bit set after a compare.
  typedef logic [2:0] res_t;

  localparam res_t RES_GT = 3'b100;
  localparam res_t RES_LT = 3'b010;
  localparam res_t RES_EQ = 3'b001;

  function automatic int cw_calc(input int ndig);
    return $clog2(ndig + 1);
  endfunction

  function automatic res_t res_encode(input logic gt, input logic lt);
    if (gt) return RES_GT;
    if (lt) return RES_LT;
    return RES_EQ;
  endfunction

endpackage

// File: rtl/bijiaoqi_digit.sv
// Combinational DIGIT-wide magnitude compare used once per cycle by
// bijiaoqi_serial on the currently selected digit.
module bijiaoqi_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/bijiaoqi_serial.sv
// Multi-cycle MSB-first digit-serial magnitude comparator with early exit.
// Define BIJIAOQI_SIGNED_EN for two's-complement operands.
module bijiaoqi_serial
  import bijiaoqi_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = cw_calc(NDIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             xgy,
  output logic             xsy,
  output logic             xey,
  output logic [CW-1:0]    cycles
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  res_t             res_q, res_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] x_cmp, y_cmp;
  logic [DIGIT-1:0] dig_x, dig_y;
  logic             dig_gt, dig_lt, dig_eq;

`ifdef BIJIAOQI_SIGNED_EN
  // Flipping the sign bit maps two's complement onto unsigned ordering.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign x_cmp = x_q ^ SIGN_MASK;
  assign y_cmp = y_q ^ SIGN_MASK;
`else
  assign x_cmp = x_q;
  assign y_cmp = y_q;
`endif

  always_comb begin
    dig_x = '0;
    dig_y = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (k_q == KW'(i)) begin
        dig_x = x_cmp[i*DIGIT +: DIGIT];
        dig_y = y_cmp[i*DIGIT +: DIGIT];
      end
    end
  end

  bijiaoqi_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (dig_x),
    .b  (dig_y),
    .gt (dig_gt),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    done_d   = 1'b0;
    res_d    = res_q;
    cycles_d = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          k_d     = KW'(NDIG - 1);
          state_d = ST_RUN;
        end
      end
      default: begin
        // Stop at the first unequal digit, or after the LSB digit matched.
        if (!dig_eq || (k_q == '0)) begin
          res_d    = res_encode(dig_gt, dig_lt);
          cycles_d = CW'(NDIG) - CW'(k_q);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      done_q   <= done_d;
      res_q    <= res_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign xgy    = res_q[2];
  assign xsy    = res_q[1];
  assign xey    = res_q[0];
  assign cycles = cycles_q;

endmodule
